// File: rtl/multi_hold_detector.sv
// Purpose: per-channel button classifier (short press, long hold, auto-repeat) with shared ms prescaler.
// Latency: btn_in edge -> output change on the 4th rising clk edge (2 sync + FSM + output register).
// Backpressure: none; pulses are fire-and-forget single-cycle strobes, long_hold is a level.
module multi_hold_detector #(
    parameter int NUM_CH      = 4,
    parameter int CLK_PER_MS  = 1000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 5000,
    parameter int REPEAT_MS   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] short_press,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] long_hold,
    output logic [NUM_CH-1:0] repeat_pulse
);

    localparam int CNT_TOP = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam int PRE_W   = $clog2(CLK_PER_MS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_CNT  = CNT_W'(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] REP_CNT  = CNT_W'(REPEAT_MS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_HELD
    } state_t;

    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  cnt_inc [NUM_CH];

    // FSM-stage event strobes, re-registered once more before reaching the ports
    logic [NUM_CH-1:0] ev_short_q, ev_short_d;
    logic [NUM_CH-1:0] ev_long_q,  ev_long_d;
    logic [NUM_CH-1:0] ev_rep_q,   ev_rep_d;

    logic [NUM_CH-1:0] short_press_q,  short_press_d;
    logic [NUM_CH-1:0] long_pulse_q,   long_pulse_d;
    logic [NUM_CH-1:0] long_hold_q,    long_hold_d;
    logic [NUM_CH-1:0] repeat_pulse_q, repeat_pulse_d;

    // Two-flop synchroniser and free-running millisecond prescaler
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        tick    = (pre_q == PRE_LAST);
        pre_d   = tick ? '0 : pre_q + 1'b1;
    end

    // Saturating increment so a counter can never wrap back into a threshold
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_inc[ch] = (cnt_q[ch] == CNT_SAT) ? cnt_q[ch] : cnt_q[ch] + 1'b1;
        end
    end

    // Per-channel press FSM; a release always wins over a same-cycle tick
    always_comb begin
        ev_short_d = '0;
        ev_long_d  = '0;
        ev_rep_d   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            case (state_q[ch])
                ST_IDLE: begin
                    cnt_d[ch] = '0;
                    if (sync2_q[ch]) begin
                        state_d[ch] = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = '0;
                    end else if (tick) begin
                        cnt_d[ch] = cnt_inc[ch];
                        if (cnt_inc[ch] == DEB_CNT) begin
                            state_d[ch] = ST_PRESSED;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch]    = ST_IDLE;
                        cnt_d[ch]      = '0;
                        ev_short_d[ch] = 1'b1;
                    end else if (tick) begin
                        if (cnt_inc[ch] == HOLD_CNT) begin
                            state_d[ch]   = ST_HELD;
                            cnt_d[ch]     = '0;
                            ev_long_d[ch] = 1'b1;
                        end else begin
                            cnt_d[ch] = cnt_inc[ch];
                        end
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = '0;
                    end else if ((REPEAT_MS > 0) && tick) begin
                        if (cnt_inc[ch] == REP_CNT) begin
                            ev_rep_d[ch] = 1'b1;
                            cnt_d[ch]    = '0;
                        end else begin
                            cnt_d[ch] = cnt_inc[ch];
                        end
                    end
                end
                default: begin
                    state_d[ch] = ST_IDLE;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    // Output register stage; long_hold follows HELD so it rises with long_pulse
    always_comb begin
        short_press_d  = ev_short_q;
        long_pulse_d   = ev_long_q;
        repeat_pulse_d = ev_rep_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            long_hold_d[ch] = (state_q[ch] == ST_HELD);
        end
    end

    // All state and outputs clear asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            pre_q          <= '0;
            ev_short_q     <= '0;
            ev_long_q      <= '0;
            ev_rep_q       <= '0;
            short_press_q  <= '0;
            long_pulse_q   <= '0;
            long_hold_q    <= '0;
            repeat_pulse_q <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                cnt_q[ch]   <= '0;
            end
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            pre_q          <= pre_d;
            ev_short_q     <= ev_short_d;
            ev_long_q      <= ev_long_d;
            ev_rep_q       <= ev_rep_d;
            short_press_q  <= short_press_d;
            long_pulse_q   <= long_pulse_d;
            long_hold_q    <= long_hold_d;
            repeat_pulse_q <= repeat_pulse_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    assign short_press  = short_press_q;
    assign long_pulse   = long_pulse_q;
    assign long_hold    = long_hold_q;
    assign repeat_pulse = repeat_pulse_q;

endmodule

// File: tb/tb_multi_hold_detector.sv
// Purpose: randomized check of multi_hold_detector against a tick-counting press model.
// Latency: model predicts outputs edge by edge, including 2-flop sync and 2 register stages.
// Backpressure: none; instance A (2 ch, repeat on) and instance B (1 ch, repeat off) share reset.
module tb_multi_hold_detector;

    localparam int A_CH = 2;
    localparam int A_CLK = 4, A_DEB = 2, A_HOLD = 5, A_REP = 3;
    localparam int B_CLK = 2, B_DEB = 3, B_HOLD = 12, B_REP = 0;
    localparam int NMOD = 3;   // model channels: 0,1 -> instance A, 2 -> instance B

    logic clk = 1'b0;
    logic reset_n;
    logic [A_CH-1:0] btn_a;
    logic [A_CH-1:0] a_sp, a_lp, a_lh, a_rp;
    logic [0:0] btn_b;
    logic [0:0] b_sp, b_lp, b_lh, b_rp;

    always #5 clk = ~clk;

    multi_hold_detector #(
        .NUM_CH(A_CH), .CLK_PER_MS(A_CLK), .DEBOUNCE_MS(A_DEB),
        .HOLD_MS(A_HOLD), .REPEAT_MS(A_REP)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_a),
        .short_press(a_sp), .long_pulse(a_lp), .long_hold(a_lh), .repeat_pulse(a_rp)
    );

    multi_hold_detector #(
        .NUM_CH(1), .CLK_PER_MS(B_CLK), .DEBOUNCE_MS(B_DEB),
        .HOLD_MS(B_HOLD), .REPEAT_MS(B_REP)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_b),
        .short_press(b_sp), .long_pulse(b_lp), .long_hold(b_lh), .repeat_pulse(b_rp)
    );

    // Per-model-channel parameters
    int p_clk [NMOD] = '{A_CLK, A_CLK, B_CLK};
    int p_deb [NMOD] = '{A_DEB, A_DEB, B_DEB};
    int p_hold[NMOD] = '{A_HOLD, A_HOLD, B_HOLD};
    int p_rep [NMOD] = '{A_REP, A_REP, B_REP};

    // Model state: press activity, ticks seen since press start, input delay line
    bit m_act[NMOD], m_s1[NMOD], m_s2[NMOD];
    int m_n[NMOD], m_edges[NMOD];
    bit e_sp[NMOD], e_lp[NMOD], e_rp[NMOD];
    bit o_sp[NMOD], o_lp[NMOD], o_rp[NMOD], o_lh[NMOD];

    // Stimulus state
    bit lvl[NMOD];
    int rem[NMOD];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int saw_short = 0, saw_long = 0, saw_rep = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NMOD; c++) begin
            m_act[c] = 0; m_s1[c] = 0; m_s2[c] = 0; m_n[c] = 0; m_edges[c] = 0;
            e_sp[c] = 0; e_lp[c] = 0; e_rp[c] = 0;
            o_sp[c] = 0; o_lp[c] = 0; o_rp[c] = 0; o_lh[c] = 0;
        end
    endtask

    // One clock edge of the reference: a press is counted in whole ticks from its start
    task automatic model_edge(input bit b[NMOD]);
        for (int c = 0; c < NMOD; c++) begin
            bit tick;
            tick = (m_edges[c] % p_clk[c]) == (p_clk[c] - 1);
            o_sp[c] = e_sp[c];
            o_lp[c] = e_lp[c];
            o_rp[c] = e_rp[c];
            o_lh[c] = m_act[c] && (m_n[c] >= p_hold[c]);
            e_sp[c] = 0; e_lp[c] = 0; e_rp[c] = 0;
            if (!m_act[c]) begin
                if (m_s2[c]) begin
                    m_act[c] = 1;
                    m_n[c] = 0;
                end
            end else if (!m_s2[c]) begin
                if (m_n[c] >= p_deb[c] && m_n[c] < p_hold[c]) e_sp[c] = 1;
                m_act[c] = 0;
            end else if (tick) begin
                m_n[c]++;
                if (m_n[c] == p_hold[c]) e_lp[c] = 1;
                else if (m_n[c] > p_hold[c] && p_rep[c] > 0 &&
                         ((m_n[c] - p_hold[c]) % p_rep[c]) == 0) e_rp[c] = 1;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = b[c];
            m_edges[c]++;
            if (o_sp[c]) saw_short++;
            if (o_lp[c]) saw_long++;
            if (o_rp[c]) saw_rep++;
        end
    endtask

    task automatic compare_all();
        check("a_short", 32'(a_sp), 32'({o_sp[1], o_sp[0]}));
        check("a_long",  32'(a_lp), 32'({o_lp[1], o_lp[0]}));
        check("a_hold",  32'(a_lh), 32'({o_lh[1], o_lh[0]}));
        check("a_rep",   32'(a_rp), 32'({o_rp[1], o_rp[0]}));
        check("b_short", 32'(b_sp), 32'(o_sp[2]));
        check("b_long",  32'(b_lp), 32'(o_lp[2]));
        check("b_hold",  32'(b_lh), 32'(o_lh[2]));
        check("b_rep",   32'(b_rp), 32'(o_rp[2]));
    endtask

    // Advance one edge: model the edge with the inputs the DUT just sampled, then compare
    task automatic step();
        bit b[NMOD];
        b[0] = btn_a[0]; b[1] = btn_a[1]; b[2] = btn_b[0];
        @(posedge clk);
        cyc++;
        model_edge(b);
        #1;
        compare_all();
    endtask

    task automatic apply_levels();
        btn_a = {lvl[1], lvl[0]};
        btn_b = lvl[2];
    endtask

    // Random press/release durations mixing glitches, short presses and long holds
    task automatic drive_random();
        for (int c = 0; c < NMOD; c++) begin
            if (rem[c] == 0) begin
                int sel;
                lvl[c] = ~lvl[c];
                sel = $urandom_range(0, 9);
                if (sel < 5)      rem[c] = $urandom_range(1, 8);
                else if (sel < 8) rem[c] = $urandom_range(8, 30);
                else              rem[c] = $urandom_range(30, 70);
            end else begin
                rem[c]--;
            end
        end
        apply_levels();
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive_random();
            step();
        end
    endtask

    // Drive ch0 into HELD, reset mid-hold, keep it held and let it re-qualify
    task automatic reset_while_held();
        bit reached;
        reached = 0;
        lvl[0] = 1;
        rem[0] = 0;
        apply_levels();
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            if (o_lh[0]) reached = 1;
        end
        check("reach_held", 32'(reached), 32'd1);
        check("held_out", 32'(a_lh[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_a_hold", 32'(a_lh), 32'd0);
        check("rst_a_pulses", 32'({a_sp, a_lp, a_rp}), 32'd0);
        check("rst_b_outs", 32'({b_sp, b_lp, b_lh, b_rp}), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rem[0] = 60;
        apply_levels();
    endtask

    initial begin
        reset_n = 1'b0;
        btn_a = '0;
        btn_b = '0;
        for (int c = 0; c < NMOD; c++) begin
            lvl[c] = 0;
            rem[c] = $urandom_range(0, 5);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'({a_sp, a_lp, a_lh, a_rp}), 32'd0);
        check("reset_b", 32'({b_sp, b_lp, b_lh, b_rp}), 32'd0);
        reset_n = 1'b1;

        run_random(1500);
        reset_while_held();
        run_random(1500);
        reset_while_held();
        run_random(1500);

        check("saw_short", 32'(saw_short > 0), 32'd1);
        check("saw_long",  32'(saw_long > 0),  32'd1);
        check("saw_rep",   32'(saw_rep > 0),   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_hold_detector.md
Name: multi_hold_detector

Overview:
- Parametrised successor to the single-input hold-to-reset block.
- Monitors NUM_CH active-high button/level inputs and classifies each press independently:
  - short press: debounced, released before the hold threshold;
  - long hold: held past HOLD_MS;
  - optional auto-repeat pulses while held.
- Sits between the keypad/button pins and the lock control FSM. Also replaces the fixed 5 s reset-hold logic: use a long_hold output with HOLD_MS=5000.

Parameters:
- NUM_CH, 4, number of independent input channels.
- CLK_PER_MS, 1000, clk cycles per millisecond tick (must be ≥2).
- DEBOUNCE_MS, 20, ticks a press must persist before it counts (≥1).
- HOLD_MS, 5000, ticks from press start to long-hold detection (> DEBOUNCE_MS).
- REPEAT_MS, 0, auto-repeat period in HELD, in ticks; 0 disables repeat.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_in  in  NUM_CH  raw asynchronous inputs, 1 = pressed.
- short_press  out  NUM_CH  1-cycle pulse on release of a debounced press shorter than HOLD_MS.
- long_pulse  out  NUM_CH  1-cycle pulse when HOLD_MS is reached.
- long_hold  out  NUM_CH  level; 1 while the channel is in HELD.
- repeat_pulse  out  NUM_CH  1-cycle pulse every REPEAT_MS ticks while in HELD.

Behaviour:
- Reset (reset_n=0, async):
  - all outputs, synchronisers, prescaler, counters = 0;
  - every channel goes to IDLE.
- Synchroniser: 2-flop per channel, btn_in → btn_s. Latency 2 clk.
- Prescaler: one shared, free-running 0..CLK_PER_MS-1. tick=1 for one cycle when the count equals CLK_PER_MS-1, then it wraps to 0.
- Per-channel counter cnt:
  - width $clog2(max(HOLD_MS,REPEAT_MS)+1);
  - saturates at its max value; never wraps.
- Per-channel FSM; all outputs are registered:
  - IDLE: cnt=0. If btn_s=1 → DEBOUNCE.
  - DEBOUNCE:
    - btn_s=0 → IDLE, no output (glitch rejected).
    - On tick: cnt+1. When cnt+1 == DEBOUNCE_MS → PRESSED.
  - PRESSED:
    - btn_s=0 → IDLE, short_press=1 for exactly the next cycle.
    - On tick: cnt+1. When cnt+1 == HOLD_MS → HELD, cnt=0, long_pulse=1 for one cycle, long_hold=1.
  - HELD:
    - long_hold=1.
    - btn_s=0 → IDLE, long_hold=0 next cycle, no short_press.
    - If REPEAT_MS>0, on tick: cnt+1. When cnt+1 == REPEAT_MS: repeat_pulse=1 for one cycle, cnt=0.
    - If REPEAT_MS=0: cnt frozen, repeat_pulse never asserts.
- Timing:
  - Tick phase is not aligned to the press, so real durations carry up to 1 ms of jitter. All thresholds are counted in ticks observed after entering DEBOUNCE.
  - Release latency: btn_in fall → output pulse visible on the 4th rising edge (2 sync + 1 FSM + 1 output register).
- Priorities:
  - Release beats tick in the same cycle: no threshold advance, release path taken.
  - Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Pulse/level rules:
  - long_pulse, short_press and repeat_pulse are never simultaneously 1 on one channel.
  - long_pulse and long_hold rise in the same cycle.
- Reset mid-operation: outputs drop asynchronously. After reset_n rises, a still-held input is treated as a new press, starting DEBOUNCE 2–3 cycles later.

Test Plan:
- Params CLK_PER_MS=4, DEBOUNCE_MS=2, HOLD_MS=5, REPEAT_MS=3, NUM_CH=2:
  - btn_in[0] pulse spanning 1 tick, then released → no output on any port.
  - btn_in[0] held across 3 ticks, then released → short_press[0]=1 for exactly 1 cycle, 4 edges after the release; long_hold stays 0.
  - btn_in[0] held across 12 ticks → long_pulse[0]=1 at the 5th tick; long_hold[0]=1 from then; repeat_pulse[0] at ticks 8 and 11; on release long_hold[0]=0 and no short_press.
  - btn_in[0] and btn_in[1] pressed 1 tick apart, both held → long_pulse on ch0 and ch1 on consecutive ticks; outputs never cross channels.
  - Release coincident with the 5th tick → short_press=1, long_pulse stays 0.
  - reset_n pulsed low while ch0 is HELD → long_hold[0]=0 immediately; with btn still held, long_pulse[0] reasserts 5 ticks after reset release.
- Params HOLD_MS=5000, CLK_PER_MS=1000, REPEAT_MS=0: hold 5 s → long_hold=1 at 5000 ticks ±1 (reset-hold equivalence); no repeat_pulse.
